// File: rtl/sound_pkg.sv
// Shared types and melody ROM for the melody player.
//   mp_state_e : player FSM states
//   melody_e   : which melody is selected
//   note_hp()  : raw half-period (50 MHz clk cycles) of a note
//   last_idx() : index of the final note of a melody
package sound_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} mp_state_e;
  typedef enum logic {MEL_WIN, MEL_LOSE} melody_e;

  // Half-periods in clk cycles at 50 MHz
  localparam logic [16:0] HP_C5 = 17'd47801;
  localparam logic [16:0] HP_E5 = 17'd37936;
  localparam logic [16:0] HP_G5 = 17'd31888;
  localparam logic [16:0] HP_C6 = 17'd23889;
  localparam logic [16:0] HP_G4 = 17'd63776;
  localparam logic [16:0] HP_E4 = 17'd75758;
  localparam logic [16:0] HP_C4 = 17'd95420;

  localparam int unsigned WIN_NOTES  = 4;
  localparam int unsigned LOSE_NOTES = 3;

  function automatic logic [16:0] note_hp(input melody_e mel, input logic [2:0] idx);
    logic [16:0] hp;
    hp = HP_C5;
    if (mel == MEL_WIN) begin
      case (idx)
        3'd0:    hp = HP_C5;
        3'd1:    hp = HP_E5;
        3'd2:    hp = HP_G5;
        default: hp = HP_C6;
      endcase
    end else begin
      case (idx)
        3'd0:    hp = HP_G4;
        3'd1:    hp = HP_E4;
        default: hp = HP_C4;
      endcase
    end
    return hp;
  endfunction

  function automatic logic [2:0] last_idx(input melody_e mel);
    return (mel == MEL_WIN) ? 3'(WIN_NOTES - 1) : 3'(LOSE_NOTES - 1);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: counts 0..half_period-1 and toggles tone on each wrap.
//   clk, resetN  : clock, async active-low reset
//   clear        : synchronous clear of counter and tone (takes priority)
//   run          : advance the counter
//   half_period  : half-period in cycles, must be >= 1
//   tone         : registered square-wave output
module tone_divider
  import sound_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic        run,
  input  logic [16:0] half_period,
  output logic        tone
);

  logic [16:0] r_cnt;
  logic        r_tone;
  logic        w_wrap;

  assign w_wrap = (r_cnt == half_period - 17'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (run) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_tone <= ~r_tone;
      end else begin
        r_cnt <= r_cnt + 17'd1;
      end
    end
  end

  assign tone = r_tone;

endmodule

// File: rtl/melody_player.sv
// Plays a fixed win or lose melody as a square wave.
//   clk, resetN : clock, async active-low reset
//   win, lose   : one-cycle trigger pulses (win has priority, ignored while busy)
//   mute        : forces tone_out low without affecting sequencing
//   tone_out    : square-wave audio
//   busy        : high while a melody is playing
//   note_idx    : index of the current note
//   done        : one-cycle pulse on the last cycle of the last note
module melody_player
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_LEN  = 12_500_000,
  parameter int unsigned GAP_LEN   = 2_500_000,
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       win,
  input  logic       lose,
  input  logic       mute,
  output logic       tone_out,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic       done
);

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_LEN - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_LEN - 1);

  mp_state_e   r_state, w_state_d;
  melody_e     r_mel, w_mel_d;
  logic [2:0]  r_note_idx, w_idx_d;
  logic [31:0] r_timer, w_timer_d;
  logic        r_busy, r_done, r_mute;

  logic [16:0] w_hp_raw, w_hp_shift, w_hp;
  logic        w_div_clear;
  logic        w_tone;

  always_comb begin
    w_state_d = r_state;
    w_mel_d   = r_mel;
    w_idx_d   = r_note_idx;
    w_timer_d = r_timer;
    unique case (r_state)
      IDLE: begin
        if (win || lose) begin
          w_mel_d   = win ? MEL_WIN : MEL_LOSE;
          w_idx_d   = 3'd0;
          w_timer_d = '0;
          w_state_d = PLAY;
        end
      end
      PLAY: begin
        if (r_timer == NOTE_LAST) begin
          w_timer_d = '0;
          w_state_d = (r_note_idx == last_idx(r_mel)) ? IDLE : GAP;
        end else begin
          w_timer_d = r_timer + 32'd1;
        end
      end
      GAP: begin
        if (r_timer == GAP_LAST) begin
          w_timer_d = '0;
          w_idx_d   = r_note_idx + 3'd1;
          w_state_d = PLAY;
        end else begin
          w_timer_d = r_timer + 32'd1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // busy and done are computed from next-state so they are registered yet line up
  // exactly with the cycle they describe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_mel      <= MEL_WIN;
      r_note_idx <= 3'd0;
      r_timer    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mute     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_mel      <= w_mel_d;
      r_note_idx <= w_idx_d;
      r_timer    <= w_timer_d;
      r_busy     <= (w_state_d != IDLE);
      r_done     <= (w_state_d == PLAY) && (w_timer_d == NOTE_LAST) &&
                    (w_idx_d == last_idx(w_mel_d));
      r_mute     <= mute;
    end
  end

  assign w_hp_raw   = note_hp(r_mel, r_note_idx);
  assign w_hp_shift = w_hp_raw >> DIV_SHIFT;
  assign w_hp       = (w_hp_shift == 17'd0) ? 17'd1 : w_hp_shift;

  // Clear on PLAY entry and whenever the next cycle is not PLAY, so every note
  // starts low and tone is 0 in GAP/IDLE.
  assign w_div_clear = (r_state != PLAY) || (w_state_d != PLAY);

  tone_divider u_tone_divider (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (w_div_clear),
    .run         (1'b1),
    .half_period (w_hp),
    .tone        (w_tone)
  );

  assign tone_out = w_tone & ~r_mute;
  assign busy     = r_busy;
  assign note_idx = r_note_idx;
  assign done     = r_done;

endmodule

// File: tb/tb_melody_player.sv
module tb_melody_player;

  localparam int NL   = 20;
  localparam int GL   = 4;
  localparam int SLOT = NL + GL;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       mute = 1'b0;
  logic       tone_out;
  logic       busy;
  logic [2:0] note_idx;
  logic       done;

  melody_player #(
    .NOTE_LEN  (NL),
    .GAP_LEN   (GL),
    .DIV_SHIFT (12)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .win      (win),
    .lose     (lose),
    .mute     (mute),
    .tone_out (tone_out),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int done_cnt;
    int done_pos;
    int idx_final;
    int idx_changes;
    int first_rise;
    int highs;
    int gap_ones;
    int last_tog;
    int last_iv;
    int nnotes;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int stray  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hand-derived expectations (NOTE_LEN 20, GAP_LEN 4, HP WIN 11/9/7/5, LOSE 15/18/23)
  function automatic exp_t exp_win(input bit muted);
    exp_t e;
    e.len = 92; e.done_cnt = 1; e.done_pos = 92; e.idx_final = 3; e.idx_changes = 3;
    e.first_rise = muted ? -1 : 11; e.highs = muted ? 0 : 35; e.gap_ones = 0;
    e.last_tog = muted ? 0 : 3; e.last_iv = muted ? 0 : 5; e.nnotes = 4;
    return e;
  endfunction

  function automatic exp_t exp_lose();
    exp_t e;
    e.len = 68; e.done_cnt = 1; e.done_pos = 68; e.idx_final = 2; e.idx_changes = 2;
    e.first_rise = 15; e.highs = 7; e.gap_ones = 0;
    e.last_tog = 0; e.last_iv = 0; e.nnotes = 3;
    return e;
  endfunction

  function automatic exp_t exp_abort40();
    exp_t e;
    e.len = 40; e.done_cnt = 0; e.done_pos = 0; e.idx_final = 1; e.idx_changes = 1;
    e.first_rise = 11; e.highs = 16; e.gap_ones = 0;
    e.last_tog = 0; e.last_iv = 0; e.nnotes = 4;
    return e;
  endfunction

  // Monitor: gathers statistics over each busy episode, compares on its end.
  int n = 0, dcnt = 0, dpos = 0, ichg = 0, idxf = 0, first = -1;
  int highs = 0, gapones = 0, tog = 0, iv = 0, last_t = 0, nn = 4;
  logic prev_tone = 1'b0;
  logic [2:0] prev_idx = 3'd0;

  always @(negedge clk) begin
    if (done && !busy) stray++;
    if (busy) begin
      n++;
      if (n == 1) begin
        dcnt = 0; dpos = 0; ichg = 0; first = -1; highs = 0; gapones = 0;
        tog = 0; iv = 0; last_t = 0; prev_tone = 1'b0; prev_idx = note_idx;
        nn = (q.size() > 0) ? q[0].nnotes : 4;
        chk("idx_start", int'(note_idx), 0);
      end
      if (done) begin dcnt++; dpos = n; end
      if (note_idx != prev_idx) begin ichg++; prev_idx = note_idx; end
      if (tone_out) begin
        highs++;
        if (first < 0) first = n - 1;
      end
      if (((n - 1) % SLOT) >= NL && tone_out) gapones++;
      if (n >= 1 + (nn - 1) * SLOT && tone_out != prev_tone) begin
        tog++;
        if (last_t > 0) iv = n - last_t;
        last_t = n;
      end
      prev_tone = tone_out;
      idxf = int'(note_idx);
    end else if (n > 0) begin
      if (q.size() == 0) begin
        chk("unexpected_episode", n, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("busy_len", n, e.len);
        chk("done_cnt", dcnt, e.done_cnt);
        chk("done_pos", dpos, e.done_pos);
        chk("idx_final", idxf, e.idx_final);
        chk("idx_changes", ichg, e.idx_changes);
        chk("first_rise", first, e.first_rise);
        chk("tone_highs", highs, e.highs);
        chk("gap_tone", gapones, e.gap_ones);
        chk("last_toggles", tog, e.last_tog);
        chk("last_interval", iv, e.last_iv);
      end
      n = 0;
    end
  end

  task automatic trig(input logic w, input logic l);
    @(posedge clk); #1;
    win = w; lose = l;
    @(posedge clk); #1;
    win = 1'b0; lose = 1'b0;
    chk("busy_after_trigger", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int viol;
    // Reset values
    #12;
    chk("rst_tone", int'(tone_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(note_idx), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy || tone_out) viol++;
    end
    chk("idle_50", viol, 0);

    // WIN
    q.push_back(exp_win(1'b0));
    trig(1'b1, 1'b0);
    wait_idle();

    // LOSE
    q.push_back(exp_lose());
    trig(1'b0, 1'b1);
    wait_idle();

    // Simultaneous triggers, plus an ignored lose during play
    q.push_back(exp_win(1'b0));
    trig(1'b1, 1'b1);
    repeat (29) @(posedge clk);
    #1 lose = 1'b1;
    @(posedge clk); #1 lose = 1'b0;
    wait_idle();

    // Muted WIN
    mute = 1'b1;
    q.push_back(exp_win(1'b1));
    trig(1'b1, 1'b0);
    wait_idle();
    mute = 1'b0;

    // Reset mid-melody at busy cycle 40
    q.push_back(exp_abort40());
    trig(1'b1, 1'b0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    #1 resetN = 1'b0;
    #1;
    chk("mid_rst_tone", int'(tone_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(note_idx), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    q.push_back(exp_lose());
    trig(1'b0, 1'b1);
    wait_idle();

    repeat (5) @(posedge clk);
    chk("stray_done", stray, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
